io_channel_host: RTL and testbench



---
 rtl/io_channel_host_if.sv | 46 ++++
 rtl/io_channel_host.sv | 204 ++++++++++++++++++++
 tb/tb_io_channel_host.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_channel_host_if.sv
// Host-side bus for io_channel_host: load/expect channels, the machine's
// input request/response channel, output capture and the check result.
interface io_channel_host_if #(
    parameter int WIDTH = 12,
    parameter int NIN   = 3,
    parameter int NOUT  = 9
);
    localparam int CW = $clog2(((NIN > NOUT) ? NIN : NOUT) + 1);

    // load phase
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic             start;

    // machine input channel
    logic             in_req;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [CW-1:0]    in_size;

    // machine output channel and end of run
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             finish;

    // check result
    logic             done;
    logic             success;
    logic [CW-1:0]    mismatch_index;

    // Host / machine side: drives the requests, observes the responses.
    modport master (
        output load_valid, load_data, exp_valid, exp_data, start,
        output in_req, out_valid, out_data, finish,
        input  in_valid, in_data, in_size, done, success, mismatch_index
    );

    // io_channel_host side.
    modport slave (
        input  load_valid, load_data, exp_valid, exp_data, start,
        input  in_req, out_valid, out_data, finish,
        output in_valid, in_data, in_size, done, success, mismatch_index
    );
endinterface

// File: rtl/io_channel_host.sv
// io_channel_host: feeds a machine under test from a preloaded input
// channel, captures the words it emits, then walks the capture against a
// preloaded expected table one index per cycle and reports the outcome.
module io_channel_host #(
    parameter int WIDTH = 12,
    parameter int NIN   = 3,
    parameter int NOUT  = 9
) (
    input  logic             clock,
    input  logic             reset,
    io_channel_host_if.slave bus
);
    localparam int CW = $clog2(((NIN > NOUT) ? NIN : NOUT) + 1);
    localparam int IW = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int OW = (NOUT > 1) ? $clog2(NOUT) : 1;

    localparam logic [CW-1:0] C_NIN  = CW'(NIN);
    localparam logic [CW-1:0] C_NOUT = CW'(NOUT);
    localparam logic [CW-1:0] C_LAST = CW'(NOUT - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_SAT  = {CW{1'b1}};

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Output-word counter: saturates so a runaway machine cannot wrap it
    // back into agreement with the expected count.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == C_SAT) ? v : v + C_ONE;
    endfunction

    state_t r_state;
    state_t w_state_nxt;

    // storage (never reset: every read is qualified by a count that is)
    logic [WIDTH-1:0] r_in_mem  [NIN];
    logic [WIDTH-1:0] r_exp_mem [NOUT];
    logic [WIDTH-1:0] r_out_mem [NOUT];

    // control / status registers
    logic [CW-1:0]    r_load_cnt;
    logic [CW-1:0]    r_exp_cnt;
    logic [CW-1:0]    r_in_pos;
    logic [CW-1:0]    r_in_size;
    logic             r_in_valid;
    logic [WIDTH-1:0] r_in_data;
    logic             r_underflow;
    logic [CW-1:0]    r_out_pos;
    logic [CW-1:0]    r_out_cnt;
    logic [CW-1:0]    r_chk_idx;
    logic [CW-1:0]    r_mismatch_index;
    logic             r_done;
    logic             r_success;

    // per-cycle strobes
    logic             w_load_we;
    logic             w_exp_we;
    logic             w_start_go;
    logic             w_in_take;
    logic             w_in_under;
    logic             w_out_we;
    logic             w_chk_en;
    logic             w_last_idx;
    logic             w_chk_fail;
    logic [CW-1:0]    w_load_cnt_nxt;
    logic [CW-1:0]    w_mm_final;

    // State register; reset aborts any phase back to LOAD.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_LOAD;
        else       r_state <= w_state_nxt;
    end

    // Next-state and per-state strobes; inputs outside their state are dropped here.
    always_comb begin
        w_state_nxt = r_state;
        w_load_we   = 1'b0;
        w_exp_we    = 1'b0;
        w_start_go  = 1'b0;
        w_in_take   = 1'b0;
        w_in_under  = 1'b0;
        w_out_we    = 1'b0;
        w_chk_en    = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_load_we  = bus.load_valid && (r_load_cnt != C_NIN);
                w_exp_we   = bus.exp_valid && (r_exp_cnt != C_NOUT);
                w_start_go = bus.start;
                if (bus.start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_in_take  = bus.in_req && (r_in_size != '0);
                w_in_under = bus.in_req && (r_in_size == '0);
                // a word arriving with finish is still captured
                w_out_we   = bus.out_valid;
                if (bus.finish) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_chk_en = 1'b1;
                if (w_last_idx) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    assign w_load_cnt_nxt = w_load_we ? (r_load_cnt + C_ONE) : r_load_cnt;
    assign w_last_idx     = (r_chk_idx == C_LAST);

    // Only indices covered by the expected table are checked; a missing
    // output word (count too small) fails the same as a wrong one.
    assign w_chk_fail = (r_chk_idx < r_exp_cnt) &&
                        ((r_out_cnt <= r_chk_idx) ||
                         (r_out_mem[r_chk_idx[OW-1:0]] != r_exp_mem[r_chk_idx[OW-1:0]]));

    // First failure seen including the current index, used when leaving CHECK.
    assign w_mm_final = ((r_mismatch_index == C_NOUT) && w_chk_fail) ? r_chk_idx
                                                                      : r_mismatch_index;

    // Load-phase counters for the input channel and the expected table.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_load_cnt <= '0;
            r_exp_cnt  <= '0;
        end else begin
            r_load_cnt <= w_load_cnt_nxt;
            if (w_exp_we) r_exp_cnt <= r_exp_cnt + C_ONE;
        end
    end

    // Memory writes: input channel, expected table, output capture.
    always_ff @(posedge clock) begin
        if (w_load_we) r_in_mem[r_load_cnt[IW-1:0]] <= bus.load_data;
        if (w_exp_we)  r_exp_mem[r_exp_cnt[OW-1:0]] <= bus.exp_data;
        if (w_out_we)  r_out_mem[r_out_pos[OW-1:0]] <= bus.out_data;
    end

    // Input channel: one-cycle response to each request, words-remaining count.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_pos    <= '0;
            r_in_size   <= '0;
            r_in_valid  <= 1'b0;
            r_in_data   <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_in_valid <= 1'b0;
            // in_pos is still zero here, so remaining = everything loaded
            if (w_start_go) r_in_size <= w_load_cnt_nxt;
            if (w_in_take) begin
                r_in_valid <= 1'b1;
                r_in_data  <= r_in_mem[r_in_pos[IW-1:0]];
                r_in_pos   <= r_in_pos + C_ONE;
                r_in_size  <= r_in_size - C_ONE;
            end
            if (w_in_under) r_underflow <= 1'b1;
        end
    end

    // Output capture: circular write pointer, saturating word count.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_pos <= '0;
            r_out_cnt <= '0;
        end else if (w_out_we) begin
            r_out_pos <= (r_out_pos == C_LAST) ? '0 : (r_out_pos + C_ONE);
            r_out_cnt <= sat_inc(r_out_cnt);
        end
    end

    // Check walk: one index per cycle, latch first failure, publish verdict.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_chk_idx        <= '0;
            r_mismatch_index <= C_NOUT;
            r_done           <= 1'b0;
            r_success        <= 1'b0;
        end else if (w_chk_en) begin
            r_chk_idx        <= r_chk_idx + C_ONE;
            r_mismatch_index <= w_mm_final;
            if (w_last_idx) begin
                r_done    <= 1'b1;
                r_success <= (w_mm_final == C_NOUT) && !r_underflow &&
                             (r_out_cnt == r_exp_cnt);
            end
        end
    end

    assign bus.in_valid       = r_in_valid;
    assign bus.in_data        = r_in_data;
    assign bus.in_size        = r_in_size;
    assign bus.done           = r_done;
    assign bus.success        = r_success;
    assign bus.mismatch_index = r_mismatch_index;

endmodule

// File: tb/tb_io_channel_host.sv
// Bench for io_channel_host: directed scenarios plus randomized runs, all
// checked against a queue-based model of the host's observable behaviour.
module tb_io_channel_host;
    localparam int W    = 12;
    localparam int NIN  = 3;
    localparam int NOUT = 9;
    localparam int SAT  = 15;

    logic clock = 1'b0;
    logic reset = 1'b1;

    io_channel_host_if #(.WIDTH(W), .NIN(NIN), .NOUT(NOUT)) bus ();

    io_channel_host #(.WIDTH(W), .NIN(NIN), .NOUT(NOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // model state
    logic [W-1:0] m_in  [$];
    logic [W-1:0] m_exp [$];
    logic [W-1:0] m_out [$];
    int           m_pos;
    bit           m_uf;
    int           m_phase;      // 0 load, 1 run, 2 check/done
    logic [W-1:0] m_in_data;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_valid = 1'b0; bus.load_data = '0;
        bus.exp_valid  = 1'b0; bus.exp_data  = '0;
        bus.start      = 1'b0; bus.in_req    = 1'b0;
        bus.out_valid  = 1'b0; bus.out_data  = '0;
        bus.finish     = 1'b0;
    endtask

    function automatic int m_remaining();
        return (m_phase == 0) ? 0 : (m_in.size() - m_pos);
    endfunction

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        chk("rst_in_valid", bus.in_valid, 0);
        chk("rst_in_data", bus.in_data, 0);
        chk("rst_in_size", bus.in_size, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_success", bus.success, 0);
        chk("rst_mismatch_index", bus.mismatch_index, NOUT);
        reset = 1'b0;
        m_in.delete(); m_exp.delete(); m_out.delete();
        m_pos = 0; m_uf = 1'b0; m_phase = 0; m_in_data = '0;
    endtask

    task automatic load(input bit lv, input logic [W-1:0] ld, input bit ev, input logic [W-1:0] ed);
        bus.load_valid = lv; bus.load_data = ld;
        bus.exp_valid  = ev; bus.exp_data  = ed;
        step();
        idle_inputs();
        if (m_phase == 0) begin
            if (lv && m_in.size() < NIN)  m_in.push_back(ld);
            if (ev && m_exp.size() < NOUT) m_exp.push_back(ed);
        end
        chk("load_in_size", bus.in_size, m_remaining());
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        idle_inputs();
        if (m_phase == 0) m_phase = 1;
        chk("start_in_size", bus.in_size, m_remaining());
    endtask

    task automatic req();
        bit exp_v;
        exp_v = 1'b0;
        bus.in_req = 1'b1;
        step();
        idle_inputs();
        if (m_phase == 1) begin
            if (m_remaining() > 0) begin
                exp_v     = 1'b1;
                m_in_data = m_in[m_pos];
                m_pos++;
            end else begin
                m_uf = 1'b1;
            end
        end
        chk("req_in_valid", bus.in_valid, exp_v);
        chk("req_in_data", bus.in_data, m_in_data);
        chk("req_in_size", bus.in_size, m_remaining());
    endtask

    task automatic out(input logic [W-1:0] w);
        bus.out_valid = 1'b1; bus.out_data = w;
        step();
        idle_inputs();
        if (m_phase == 1) m_out.push_back(w);
        chk("out_in_valid", bus.in_valid, 0);
        chk("out_done", bus.done, 0);
    endtask

    // Expected verdict straight from the capture rules: circular store,
    // latest writer wins, count saturates.
    task automatic expect_result(output int mm, output bit succ);
        logic [W-1:0] mem [NOUT];
        int cnt;
        for (int i = 0; i < NOUT; i++) mem[i] = '0;
        for (int k = 0; k < m_out.size(); k++) mem[k % NOUT] = m_out[k];
        cnt = (m_out.size() > SAT) ? SAT : m_out.size();
        mm  = NOUT;
        for (int i = 0; i < m_exp.size(); i++) begin
            if (i >= cnt || mem[i] != m_exp[i]) begin
                mm = i;
                break;
            end
        end
        succ = (mm == NOUT) && !m_uf && (cnt == m_exp.size());
    endtask

    task automatic raise_finish(input bit with_out, input logic [W-1:0] w);
        bus.finish = 1'b1; bus.out_valid = with_out; bus.out_data = w;
        step();
        idle_inputs();
        if (m_phase == 1 && with_out) m_out.push_back(w);
        m_phase = 2;
    endtask

    task automatic finish_and_check(input string tag, input bit with_out, input logic [W-1:0] w);
        int  mm;
        bit  succ;
        raise_finish(with_out, w);
        expect_result(mm, succ);
        for (int c = 1; c <= NOUT; c++) begin
            step();
            if (c == NOUT - 1) chk({tag, "_done_early"}, bus.done, 0);
        end
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_success"}, bus.success, succ);
        chk({tag, "_mismatch_index"}, bus.mismatch_index, mm);
        // DONE holds and ignores start/load traffic
        bus.start = 1'b1; bus.load_valid = 1'b1; bus.exp_valid = 1'b1;
        step();
        idle_inputs();
        step();
        chk({tag, "_done_hold"}, bus.done, 1);
        chk({tag, "_success_hold"}, bus.success, succ);
        chk({tag, "_mm_hold"}, bus.mismatch_index, mm);
    endtask

    // Nominal program: load/expect, start, echo words, then drain the input
    // channel emitting (remaining, data) pairs. bad_idx corrupts one output.
    task automatic nominal_run(input int bad_idx);
        logic [W-1:0] ld [3];
        logic [W-1:0] ex [9];
        logic [W-1:0] w;
        int n;
        int guard;
        ld = '{12'd33, 12'd22, 12'd11};
        ex = '{12'd1, 12'd2, 12'd3, 12'd3, 12'd33, 12'd2, 12'd22, 12'd1, 12'd11};
        do_reset();
        for (int i = 0; i < NOUT; i++) load(i < 3, (i < 3) ? ld[i] : 12'd0, 1'b1, ex[i]);
        do_start();
        chk("nom_in_size_first", bus.in_size, 3);
        // load in RUN must be ignored
        load(1'b1, 12'd77, 1'b1, 12'd78);
        n = 0;
        for (int i = 1; i <= 3; i++) begin
            w = (n == bad_idx) ? 12'd34 : W'(i);
            out(w); n++;
        end
        guard = 0;
        while (m_remaining() > 0 && guard < 8) begin
            chk("nom_loop_in_size", bus.in_size, m_remaining());
            w = W'(m_remaining());
            req();
            if (n == bad_idx) w = 12'd34;
            out(w); n++;
            w = (n == bad_idx) ? 12'd34 : m_in_data;
            out(w); n++;
            guard++;
        end
        chk("nom_in_size_empty", bus.in_size, 0);
    endtask

    initial begin
        int mm;
        bit succ;
        logic [W-1:0] v;
        idle_inputs();

        // nominal pass
        nominal_run(-1);
        finish_and_check("nominal", 1'b0, '0);
        chk("nominal_success_const", bus.success, 1);
        chk("nominal_mm_const", bus.mismatch_index, 9);

        // single corrupted output word
        nominal_run(4);
        finish_and_check("mismatch", 1'b0, '0);
        chk("mismatch_mm_const", bus.mismatch_index, 4);

        // underflow: one word, two requests
        do_reset();
        v = W'($urandom_range(0, 4095));
        load(1'b1, v, 1'b1, v);
        do_start();
        chk("uf_size1", bus.in_size, 1);
        req();
        chk("uf_first_valid", bus.in_valid, 1);
        req();
        chk("uf_second_valid", bus.in_valid, 0);
        out(m_in_data);
        finish_and_check("underflow", 1'b0, '0);
        chk("uf_success_const", bus.success, 0);

        // wrap-around: ten outputs into a nine-word capture, last with finish
        do_reset();
        for (int i = 1; i <= NOUT; i++) load(1'b0, '0, 1'b1, W'(i));
        do_start();
        for (int i = 1; i <= NOUT; i++) out(W'(i));
        finish_and_check("wrap", 1'b1, 12'd10);
        chk("wrap_mm_const", bus.mismatch_index, 0);

        // output word coinciding with finish must be captured and checked
        do_reset();
        load(1'b0, '0, 1'b1, 12'd5);
        load(1'b0, '0, 1'b1, 12'd6);
        do_start();
        out(12'd5);
        finish_and_check("out_with_finish", 1'b1, 12'd6);
        chk("owf_success_const", bus.success, 1);

        // reset in the middle of CHECK
        nominal_run(-1);
        raise_finish(1'b0, '0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("midchk_done", bus.done, 0);
        chk("midchk_success", bus.success, 0);
        chk("midchk_in_size", bus.in_size, 0);
        chk("midchk_mm", bus.mismatch_index, NOUT);
        reset = 1'b0;
        nominal_run(-1);
        finish_and_check("after_reset", 1'b0, '0);

        // randomized programs
        for (int it = 0; it < 12; it++) begin
            int nl, ne, nops, op;
            do_reset();
            nl = $urandom_range(0, 4);
            ne = $urandom_range(0, 9);
            for (int i = 0; i < ((nl > ne) ? nl : ne); i++)
                load(i < nl, W'($urandom_range(0, 4095)), i < ne, W'($urandom_range(0, 4095)));
            do_start();
            nops = $urandom_range(0, 14);
            for (int k = 0; k < nops; k++) begin
                op = $urandom_range(0, 9);
                if (op < 3) begin
                    req();
                end else if (op < 9) begin
                    if (m_out.size() < m_exp.size() && $urandom_range(0, 9) < 8)
                        out(m_exp[m_out.size()]);
                    else
                        out(W'($urandom_range(0, 4095)));
                end else begin
                    load(1'b1, W'($urandom_range(0, 4095)), 1'b1, W'($urandom_range(0, 4095)));
                end
            end
            if ($urandom_range(0, 1) == 1 && m_out.size() < m_exp.size())
                finish_and_check("rand", 1'b1, m_exp[m_out.size()]);
            else
                finish_and_check("rand", 1'b0, '0);
            expect_result(mm, succ);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
